// File: rtl/sap1_pkg.sv
// Shared SAP-1 constants: opcodes, control-word microcode constants and T-state encoding.
package sap1_pkg;

  typedef logic [3:0]  opcode_t;
  typedef logic [11:0] cw_t;
  typedef logic [2:0]  tstate_t;

  localparam opcode_t OP_LDA = 4'b0000;
  localparam opcode_t OP_ADD = 4'b0001;
  localparam opcode_t OP_SUB = 4'b0010;
  localparam opcode_t OP_OUT = 4'b1110;
  localparam opcode_t OP_HLT = 4'b1111;

  localparam cw_t CW_FETCH1      = 12'h090;
  localparam cw_t CW_FETCH2      = 12'h1A0;
  localparam cw_t CW_NOP         = 12'h000;
  localparam cw_t CW_ADDR_TO_MAR = 12'h090;
  localparam cw_t CW_RAM_TO_A    = 12'h120;
  localparam cw_t CW_RAM_TO_B    = 12'h108;
  localparam cw_t CW_ALU_ADD     = 12'h024;
  localparam cw_t CW_ALU_SUB     = 12'h026;
  localparam cw_t CW_A_TO_OUT    = 12'h401;

  localparam tstate_t T_IDLE = 3'd0;
  localparam tstate_t T1     = 3'd1;
  localparam tstate_t T2     = 3'd2;
  localparam tstate_t T3     = 3'd3;
  localparam tstate_t T4     = 3'd4;
  localparam tstate_t T5     = 3'd5;
  localparam tstate_t T6     = 3'd6;

endpackage

// File: rtl/controller_if.sv
// IR-to-controller-to-datapath bus: opcode in, control word and halt out.
interface controller_if;
  import sap1_pkg::*;

  opcode_t opcode;
  cw_t     cw;
  logic    halt;

  modport master (output opcode, input cw, input halt);
  modport slave  (input opcode, output cw, output halt);
endinterface

// File: rtl/controller_ring_counter.sv
// Six-state T-counter: idle(0) -> T1..T6 -> T1, frozen while hold is high.
module ring_counter
  import sap1_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    hold,
  output tstate_t t_state
);

  tstate_t t_next;

  always_ff @(posedge clk) begin
    if (rst) t_state <= T_IDLE;
    else     t_state <= t_next;
  end

  // Unused code 7 falls back into T1 so the ring always recovers.
  always_comb begin
    t_next = t_state;
    if (!hold) begin
      if (t_state >= T6) t_next = T1;
      else               t_next = t_state + 3'd1;
    end
  end

endmodule

// File: rtl/controller.sv
// SAP-1 microprogrammed controller: halt register plus combinational microcode decode.
module controller
  import sap1_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  controller_if.slave   bus
);

  tstate_t t_state;
  logic    halt_q;
  logic    halt_set;
  cw_t     cw_dec;

  // Freeze in T4 on the very edge that latches halt, so the counter never leaves T4.
  assign halt_set = (t_state == T4) && (bus.opcode == OP_HLT);

  ring_counter u_ring (
    .clk     (clk),
    .rst     (rst),
    .hold    (halt_q | halt_set),
    .t_state (t_state)
  );

  always_ff @(posedge clk) begin
    if (rst)           halt_q <= 1'b0;
    else if (halt_set) halt_q <= 1'b1;
  end

  always_comb begin
    cw_dec = CW_NOP;
    case (t_state)
      T1: cw_dec = CW_FETCH1;
      T2: cw_dec = CW_FETCH2;
      T3: cw_dec = CW_NOP;
      T4: case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: cw_dec = CW_ADDR_TO_MAR;
            OP_OUT:                 cw_dec = CW_A_TO_OUT;
            default:                cw_dec = CW_NOP;
          endcase
      T5: case (bus.opcode)
            OP_LDA:         cw_dec = CW_RAM_TO_A;
            OP_ADD, OP_SUB: cw_dec = CW_RAM_TO_B;
            default:        cw_dec = CW_NOP;
          endcase
      T6: case (bus.opcode)
            OP_ADD:  cw_dec = CW_ALU_ADD;
            OP_SUB:  cw_dec = CW_ALU_SUB;
            default: cw_dec = CW_NOP;
          endcase
      default: cw_dec = CW_NOP;
    endcase
  end

  assign bus.cw   = halt_q ? CW_NOP : cw_dec;
  assign bus.halt = halt_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for the SAP-1 controller: fetch/execute words, halt freeze and reset priority.
module tb_controller;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  controller_if bus ();

  controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then compare state, control word and halt at the falling edge.
  task automatic cyc(input string tag, input logic [2:0] t, input logic [11:0] c, input logic h);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".t_state"}, {9'd0, dut.t_state}, {9'd0, t});
    chk({tag, ".cw"}, bus.cw, c);
    chk({tag, ".halt"}, {11'd0, bus.halt}, {11'd0, h});
  endtask

  initial begin
    rst = 1'b1;
    bus.opcode = 4'b0000;
    cyc("reset", 3'd0, 12'h000, 1'b0);
    rst = 1'b0;

    // LDA
    cyc("lda_t1", 3'd1, 12'h090, 1'b0);
    cyc("lda_t2", 3'd2, 12'h1A0, 1'b0);
    cyc("lda_t3", 3'd3, 12'h000, 1'b0);
    cyc("lda_t4", 3'd4, 12'h090, 1'b0);
    cyc("lda_t5", 3'd5, 12'h120, 1'b0);
    cyc("lda_t6", 3'd6, 12'h000, 1'b0);

    // ADD
    bus.opcode = 4'b0001;
    cyc("add_t1", 3'd1, 12'h090, 1'b0);
    cyc("add_t2", 3'd2, 12'h1A0, 1'b0);
    cyc("add_t3", 3'd3, 12'h000, 1'b0);
    cyc("add_t4", 3'd4, 12'h090, 1'b0);
    cyc("add_t5", 3'd5, 12'h108, 1'b0);
    cyc("add_t6", 3'd6, 12'h024, 1'b0);

    // SUB
    bus.opcode = 4'b0010;
    cyc("sub_t1", 3'd1, 12'h090, 1'b0);
    cyc("sub_t2", 3'd2, 12'h1A0, 1'b0);
    cyc("sub_t3", 3'd3, 12'h000, 1'b0);
    cyc("sub_t4", 3'd4, 12'h090, 1'b0);
    cyc("sub_t5", 3'd5, 12'h108, 1'b0);
    cyc("sub_t6", 3'd6, 12'h026, 1'b0);

    // OUT
    bus.opcode = 4'b1110;
    cyc("out_t1", 3'd1, 12'h090, 1'b0);
    cyc("out_t2", 3'd2, 12'h1A0, 1'b0);
    cyc("out_t3", 3'd3, 12'h000, 1'b0);
    cyc("out_t4", 3'd4, 12'h401, 1'b0);
    cyc("out_t5", 3'd5, 12'h000, 1'b0);
    cyc("out_t6", 3'd6, 12'h000, 1'b0);

    // NOP opcode executes nothing
    bus.opcode = 4'b0111;
    cyc("nop_t1", 3'd1, 12'h090, 1'b0);
    cyc("nop_t2", 3'd2, 12'h1A0, 1'b0);
    cyc("nop_t3", 3'd3, 12'h000, 1'b0);
    cyc("nop_t4", 3'd4, 12'h000, 1'b0);
    cyc("nop_t5", 3'd5, 12'h000, 1'b0);
    cyc("nop_t6", 3'd6, 12'h000, 1'b0);

    // HLT: halt latches on the edge taken in T4, then everything freezes
    bus.opcode = 4'b1111;
    cyc("hlt_t1", 3'd1, 12'h090, 1'b0);
    cyc("hlt_t2", 3'd2, 12'h1A0, 1'b0);
    cyc("hlt_t3", 3'd3, 12'h000, 1'b0);
    cyc("hlt_t4", 3'd4, 12'h000, 1'b0);
    cyc("hlt_set", 3'd4, 12'h000, 1'b1);
    bus.opcode = 4'b0000;
    for (int i = 0; i < 10; i++) cyc("hlt_hold", 3'd4, 12'h000, 1'b1);

    // Reset out of halt
    rst = 1'b1;
    cyc("hlt_rst", 3'd0, 12'h000, 1'b0);
    rst = 1'b0;
    cyc("rst_t1", 3'd1, 12'h090, 1'b0);
    cyc("rst_t2", 3'd2, 12'h1A0, 1'b0);
    cyc("rst_t3", 3'd3, 12'h000, 1'b0);
    cyc("rst_t4", 3'd4, 12'h090, 1'b0);
    cyc("rst_t5", 3'd5, 12'h120, 1'b0);

    // Mid-instruction reset from T5
    rst = 1'b1;
    cyc("mid_rst", 3'd0, 12'h000, 1'b0);
    rst = 1'b0;
    cyc("mid_t1", 3'd1, 12'h090, 1'b0);

    // Reset beats the edge that would latch halt
    bus.opcode = 4'b1111;
    cyc("pri_t2", 3'd2, 12'h1A0, 1'b0);
    cyc("pri_t3", 3'd3, 12'h000, 1'b0);
    cyc("pri_t4", 3'd4, 12'h000, 1'b0);
    rst = 1'b1;
    cyc("pri_rst", 3'd0, 12'h000, 1'b0);
    rst = 1'b0;
    bus.opcode = 4'b0000;
    cyc("pri_t1", 3'd1, 12'h090, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
